// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, requester IDs and the
// read-burst alignment helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Clears the low log2(beats)+2 address bits so a burst starts on its span.
    function automatic logic [ADDR_W-1:0] burst_align(input logic [ADDR_W-1:0] addr,
                                                      input int unsigned       beats);
        logic [ADDR_W-1:0] span;
        span = ADDR_W'(beats * 4);
        return addr & ~(span - ADDR_W'(1));
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side handshake bundle of the memory arbiter.
// slave: the arbiter's view; master: the caches and memory around it.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              ic_req_valid;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_req_ready;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;

    logic              dc_req_valid;
    logic              dc_req_we;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_req_wdata;
    logic              dc_req_ready;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/mem_arb_beat_counter.sv
// Counts memory beats accepted in RESP; last flags the final beat of a burst.
module mem_arb_beat_counter #(
    parameter int unsigned BEATS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic last
);

    localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (incr) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign last = (count_q == CW'(BEATS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter onto a single memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants; default is fixed dcache priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BEATS = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    req_id_e           owner_q;
    req_id_e           grant_id;
    logic              grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              beat_incr;
    logic              beat_last;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_e ptr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= REQ_DC;
        end else if (grant) begin
            ptr_q <= (grant_id == REQ_IC) ? REQ_DC : REQ_IC;
        end
    end

    always_comb begin
        grant_id = REQ_IC;
        if (bus.ic_req_valid && bus.dc_req_valid) begin
            grant_id = ptr_q;
        end else if (bus.dc_req_valid) begin
            grant_id = REQ_DC;
        end
    end
`else
    always_comb begin
        grant_id = bus.dc_req_valid ? REQ_DC : REQ_IC;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every output is gated by reset so nothing asserts while reset is low,
    // even in the cycle before the synchronous reset edge.
    always_comb begin
        state_d           = state_q;
        grant             = 1'b0;
        beat_incr         = 1'b0;
        bus.ic_req_ready  = 1'b0;
        bus.dc_req_ready  = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.ic_resp_valid = 1'b0;
        bus.dc_resp_valid = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ic_req_valid || bus.dc_req_valid) begin
                        grant            = 1'b1;
                        bus.ic_req_ready = (grant_id == REQ_IC);
                        bus.dc_req_ready = (grant_id == REQ_DC);
                        state_d          = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus.mem_req_valid = 1'b1;
                    if (bus.mem_req_ready) begin
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.mem_resp_valid) begin
                        beat_incr         = 1'b1;
                        bus.ic_resp_valid = (owner_q == REQ_IC);
                        bus.dc_resp_valid = (owner_q == REQ_DC);
                        if (we_q || beat_last) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q <= REQ_DC;
            we_q    <= 1'b0;
        end else if (grant) begin
            owner_q <= grant_id;
            we_q    <= (grant_id == REQ_DC) && bus.dc_req_we;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            if (grant_id == REQ_DC) begin
                addr_q  <= bus.dc_req_we ? bus.dc_req_addr : burst_align(bus.dc_req_addr, BEATS);
                wdata_q <= bus.dc_req_wdata;
            end else begin
                addr_q  <= burst_align(bus.ic_req_addr, BEATS);
                wdata_q <= '0;
            end
        end
    end

    mem_arb_beat_counter #(
        .BEATS (BEATS)
    ) u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .clear (grant),
        .incr  (beat_incr),
        .last  (beat_last)
    );

    assign bus.mem_req_we    = we_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.ic_resp_data  = bus.mem_resp_data;
    assign bus.dc_resp_data  = bus.mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random cache traffic and a randomized memory,
// expected grants/addresses/beats come from a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned BEATS = 4;
    localparam int unsigned TMO   = 500;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(
        .BEATS (BEATS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          owner;   // 0 = icache, 1 = dcache
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int unsigned k);
        return (a * 32'h9E37_79B1) ^ (32'(k) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    // ---------------- reference model ----------------
    txn_t ic_list[$];
    txn_t dc_list[$];
    txn_t exp_q[$];
    bit   model_ptr = 1'b1;

    task automatic plan_round();
        int unsigned i = 0;
        int unsigned j = 0;
        bit w;
        txn_t t;
        while (i < ic_list.size() || j < dc_list.size()) begin
            if (i < ic_list.size() && j < dc_list.size()) w = RR_EN ? model_ptr : 1'b1;
            else w = (j < dc_list.size());
            if (w) begin t = dc_list[j]; j++; end
            else   begin t = ic_list[i]; i++; end
            if (!t.we) t.addr = (t.addr / (BEATS * 4)) * (BEATS * 4);
            exp_q.push_back(t);
            model_ptr = !w;
        end
    endtask

    task automatic gen_round(input int unsigned nic, input int unsigned ndc);
        txn_t t;
        ic_list.delete();
        dc_list.delete();
        for (int k = 0; k < int'(nic); k++) begin
            t.owner = 1'b0; t.we = 1'b0; t.addr = $urandom; t.wdata = '0;
            ic_list.push_back(t);
        end
        for (int k = 0; k < int'(ndc); k++) begin
            t.owner = 1'b1; t.we = 1'($urandom_range(0, 1)); t.addr = $urandom; t.wdata = $urandom;
            dc_list.push_back(t);
        end
    endtask

    // ---------------- requester drivers ----------------
    task automatic drive_ic();
        int unsigned n;
        foreach (ic_list[k]) begin
            bus.ic_req_valid = 1'b1;
            bus.ic_req_addr  = ic_list[k].addr;
            n = 0;
            @(negedge clk);
            while (!bus.ic_req_ready && n < TMO) begin n++; @(negedge clk); end
            check("ic_grant_in_time", 64'(n < TMO), 1);
            if (n >= TMO) break;
            @(posedge clk); #1;
        end
        bus.ic_req_valid = 1'b0;
    endtask

    task automatic drive_dc();
        int unsigned n;
        foreach (dc_list[k]) begin
            bus.dc_req_valid = 1'b1;
            bus.dc_req_we    = dc_list[k].we;
            bus.dc_req_addr  = dc_list[k].addr;
            bus.dc_req_wdata = dc_list[k].wdata;
            n = 0;
            @(negedge clk);
            while (!bus.dc_req_ready && n < TMO) begin n++; @(negedge clk); end
            check("dc_grant_in_time", 64'(n < TMO), 1);
            if (n >= TMO) break;
            @(posedge clk); #1;
        end
        bus.dc_req_valid = 1'b0;
    endtask

    // ---------------- memory responder ----------------
    bit          rsp_busy = 1'b0;
    bit          lat_loaded = 1'b0;
    int          lat, gap;
    int          fixed_lat = -1;
    int          fixed_gap = -1;
    bit          stray_en  = 1'b1;
    logic [31:0] cap_addr;
    bit          cap_we;
    int unsigned rbeat;

    function automatic int pick_gap();
        return (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 2));
    endfunction

    initial begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = $urandom;
            if (!reset) begin
                rsp_busy   = 1'b0;
                lat_loaded = 1'b0;
            end else if (rsp_busy) begin
                if (gap > 0) gap--;
                else begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = beat_data(cap_addr, rbeat);
                    rbeat++;
                    gap = pick_gap();
                    if (rbeat == (cap_we ? 1 : BEATS)) rsp_busy = 1'b0;
                end
            end else if (bus.mem_req_valid) begin
                if (!lat_loaded) begin
                    lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                    lat_loaded = 1'b1;
                end
                if (lat == 0) begin
                    bus.mem_req_ready = 1'b1;
                    cap_addr   = bus.mem_req_addr;
                    cap_we     = bus.mem_req_we;
                    rsp_busy   = 1'b1;
                    rbeat      = 0;
                    gap        = pick_gap();
                    lat_loaded = 1'b0;
                end else begin
                    lat--;
                    if (stray_en && $urandom_range(0, 2) == 0) bus.mem_resp_valid = 1'b1;
                end
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
                bus.mem_resp_valid = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          mon_phase = 0;   // 0 idle, 1 issue, 2 resp
    txn_t        cur;
    int unsigned mon_beat = 0;
    int unsigned issue_cycles = 0;
    bit          grant_log[$];
    logic [31:0] last_addr, last_wdata;
    logic        last_we;
    logic        owner_v, other_v;

    always @(negedge clk) begin
        if (!reset) begin
            check("reset_outputs", {bus.ic_req_ready, bus.dc_req_ready, bus.mem_req_valid,
                                    bus.ic_resp_valid, bus.dc_resp_valid}, 0);
            mon_phase = 0;
        end else begin
            case (mon_phase)
                0: begin
                    check("idle_outputs", {bus.mem_req_valid, bus.ic_resp_valid, bus.dc_resp_valid}, 0);
                    if (bus.ic_req_ready || bus.dc_req_ready) begin
                        check("single_grant", 64'(bus.ic_req_ready & bus.dc_req_ready), 0);
                        check("grant_expected", 64'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            cur = exp_q.pop_front();
                            check("grant_owner", 64'(bus.dc_req_ready), 64'(cur.owner));
                            grant_log.push_back(bus.dc_req_ready);
                            mon_phase = 1;
                            issue_cycles = 0;
                        end
                    end
                end
                1: begin
                    check("issue_outputs", {bus.ic_req_ready, bus.dc_req_ready, bus.ic_resp_valid,
                                            bus.dc_resp_valid, bus.mem_req_valid}, 5'b00001);
                    check("issue_we", 64'(bus.mem_req_we), 64'(cur.we));
                    check("issue_addr", bus.mem_req_addr, cur.addr);
                    if (cur.we) check("issue_wdata", bus.mem_req_wdata, cur.wdata);
                    issue_cycles++;
                    if (bus.mem_req_ready) begin
                        last_addr  = bus.mem_req_addr;
                        last_wdata = bus.mem_req_wdata;
                        last_we    = bus.mem_req_we;
                        mon_phase  = 2;
                        mon_beat   = 0;
                    end
                end
                default: begin
                    check("resp_outputs", {bus.ic_req_ready, bus.dc_req_ready, bus.mem_req_valid}, 0);
                    owner_v = cur.owner ? bus.dc_resp_valid : bus.ic_resp_valid;
                    other_v = cur.owner ? bus.ic_resp_valid : bus.dc_resp_valid;
                    check("resp_forward", {owner_v, other_v}, {bus.mem_resp_valid, 1'b0});
                    if (owner_v) begin
                        if (!cur.we)
                            check("resp_data", cur.owner ? bus.dc_resp_data : bus.ic_resp_data,
                                  beat_data(cur.addr, mon_beat));
                        mon_beat++;
                        if (mon_beat == (cur.we ? 1 : BEATS)) mon_phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic wait_drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || mon_phase != 0) && n < TMO) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_in_time", 64'(n < TMO), 1);
        @(posedge clk); #1;
    endtask

    task automatic run_round();
        plan_round();
        fork
            drive_ic();
            drive_dc();
        join
        wait_drain();
    endtask

    initial begin
        txn_t t;
        logic [3:0] got4;
        int unsigned n;
        bus.ic_req_valid = 1'b0; bus.ic_req_addr = '0;
        bus.dc_req_valid = 1'b0; bus.dc_req_we = 1'b0;
        bus.dc_req_addr  = '0;   bus.dc_req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // contended traffic straight after reset: pointer starts at dcache
        gen_round(4, 4);
        grant_log.delete();
        run_round();
        got4 = '0;
        for (int k = 0; k < 4 && k < grant_log.size(); k++) got4[3-k] = grant_log[k];
        check("contended_order", got4, RR_EN ? 4'b1010 : 4'b1111);

        // icache burst with ready on the third ISSUE cycle
        fixed_lat = 2; stray_en = 1'b0;
        ic_list.delete(); dc_list.delete();
        t.owner = 1'b0; t.we = 1'b0; t.addr = 32'h0000_1234; t.wdata = '0;
        ic_list.push_back(t);
        run_round();
        check("ic_issue_cycles", issue_cycles, 3);
        check("ic_aligned_addr", last_addr, 32'h0000_1230);

        // dcache single-word write
        ic_list.delete(); dc_list.delete();
        t.owner = 1'b1; t.we = 1'b1; t.addr = 32'h0000_2004; t.wdata = 32'hDEAD_BEEF;
        dc_list.push_back(t);
        run_round();
        check("dc_write_fields", {last_we, last_addr, last_wdata}, {1'b1, 32'h0000_2004, 32'hDEAD_BEEF});

        // stray memory beats while idle and while waiting in ISSUE
        fixed_lat = 3; stray_en = 1'b1;
        gen_round(1, 1);
        run_round();
        fixed_lat = -1;

        for (int r = 0; r < 30; r++) begin
            int unsigned a, b;
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            if (a == 0 && b == 0) a = 1;
            gen_round(a, b);
            run_round();
        end

        // reset after the second beat of an icache read
        fixed_gap = 1;
        gen_round(1, 0);
        plan_round();
        drive_ic();
        n = 0;
        while (!(mon_phase == 2 && mon_beat == 2) && n < TMO) begin
            @(negedge clk); #1;
            n++;
        end
        check("reached_beat2", 64'(n < TMO), 1);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        exp_q.delete();
        model_ptr = 1'b1;
        fixed_gap = -1;
        repeat (2) @(posedge clk);
        #1;
        gen_round(1, 0);
        grant_log.delete();
        run_round();
        check("post_reset_grant", 64'(grant_log.size()), 1);

        // pointer returned to dcache by the mid-transaction reset
        gen_round(2, 2);
        grant_log.delete();
        run_round();
        got4 = '0;
        for (int k = 0; k < 4 && k < grant_log.size(); k++) got4[3-k] = grant_log[k];
        check("post_reset_order", got4, RR_EN ? 4'b1010 : 4'b1100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be:
  BEATS  4  words per read burst (power of two, 2..16)
REQ-002 Ports SHALL be:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous, active-low reset
  ic_req_valid  in  1  icache refill request
  ic_req_addr  in  32  icache refill byte address
  ic_req_ready  out  1  icache request accepted (1-cycle pulse)
  ic_resp_valid  out  1  icache refill beat valid
  ic_resp_data  out  32  icache refill beat
  dc_req_valid  in  1  dcache request
  dc_req_we  in  1  1 = single-word write, 0 = burst read
  dc_req_addr  in  32  dcache byte address
  dc_req_wdata  in  32  dcache write word
  dc_req_ready  out  1  dcache request accepted (1-cycle pulse)
  dc_resp_valid  out  1  dcache read beat or write ack
  dc_resp_data  out  32  dcache read beat
  mem_req_valid  out  1  request to main memory
  mem_req_ready  in  1  memory accepts request
  mem_req_we  out  1  write request
  mem_req_addr  out  32  memory byte address
  mem_req_wdata  out  32  memory write word
  mem_resp_valid  in  1  memory beat or write ack
  mem_resp_data  in  32  memory beat

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-004 In IDLE with any request valid, the block SHALL grant one requester, capture its addr/we/wdata, pulse that requester's *_req_ready for exactly that cycle, and enter ISSUE next cycle.
REQ-005 Requesters SHALL hold valid/addr/we/wdata stable until their ready pulse; the ready pulse SHALL occur only in IDLE.
REQ-006 ISSUE SHALL drive mem_req_valid=1 with captured fields, holding them stable until mem_req_ready=1, then enter RESP.
REQ-007 Read address SHALL be aligned down to BEATS*4 bytes (low log2(BEATS)+2 bits zero); write address SHALL pass unmodified; icache requests SHALL always issue mem_req_we=0.
REQ-008 RESP SHALL forward mem_resp_valid/mem_resp_data combinationally (zero latency) to the owner only; the non-owner resp_valid SHALL stay 0.
REQ-009 A beat counter SHALL count accepted beats; RESP SHALL exit to IDLE on beat BEATS (read) or on beat 1 (write ack).
REQ-010 mem_resp_valid outside RESP SHALL be ignored.
REQ-011 Grant SHALL be evaluated no earlier than the cycle after RESP exit; back-to-back transactions SHALL therefore be separated by at least one IDLE cycle.
REQ-012 *_resp_data SHALL equal mem_resp_data whenever the corresponding resp_valid=1 and SHALL be don't-care otherwise.

Reset
REQ-013 With reset=0 at a clock edge, the FSM SHALL enter IDLE, the beat counter SHALL clear and the priority pointer SHALL point to dcache.
REQ-014 During reset and after it, mem_req_valid, ic_req_ready, dc_req_ready, ic_resp_valid and dc_resp_valid SHALL be 0.
REQ-015 Reset mid-transaction SHALL abandon the transaction; the memory system SHALL be reset concurrently.

Configuration
REQ-016 With MEM_ARB_ROUND_ROBIN_EN defined, the winner SHALL alternate when both requesters are valid, and the pointer SHALL move to the loser after each grant.
REQ-017 Without MEM_ARB_ROUND_ROBIN_EN, dcache SHALL always win simultaneous requests, and no pointer register SHALL exist.

Structure
REQ-018 FSM state encodings and requester IDs (IC=0, DC=1) SHALL reside in shared package mem_arb_pkg.
REQ-019 The beat counter SHALL be sub-module mem_arb_beat_counter (clear, increment, last flag).

Verification
REQ-020 Icache read of 0x0000_1234, mem_req_ready on the 3rd ISSUE cycle -> mem_req_addr=0x0000_1230 held over 3 cycles; 4 beats forwarded to ic_resp only; IDLE after beat 4.
REQ-021 Dcache write of 0xDEADBEEF to 0x0000_2004 -> mem_req_we=1, addr 0x0000_2004, wdata 0xDEADBEEF; one ack on dc_resp_valid; IDLE next cycle.
REQ-022 Both requests valid continuously for 4 transactions -> with the macro, grants go DC,IC,DC,IC; without it, grants go DC,DC,DC,DC.
REQ-023 mem_resp_valid pulsed while in IDLE and ISSUE -> no resp_valid output asserts, and the beat counter is unchanged.
REQ-024 reset=0 asserted after beat 2 of a read -> next cycle in IDLE with all outputs 0; a new icache request is then granted normally.
